// File: rtl/uart_tx_feeder.sv
// -----------------------------------------------------------------------------
// uart_tx_feeder
//
// Frame queue and launch sequencer that sits directly in front of a UART
// transmitter. Core logic pushes frames into a synchronous FIFO. One frame at
// a time is popped into a holding register. A rising-edge start request is
// then issued. The next frame is not launched until the transmitter's
// stop-bit done level has been seen to rise and then fall.
//
// Parameters
//   DATA_FRAME : frame width in bits (5..9), must match the transmitter
//   DEPTH      : FIFO entries, power of two, 2..256
//   START_HOLD : cycles o_tx_start is held high per frame, >= 1
//
// Ports
//   i_clk        system clock
//   i_rst        synchronous active-high reset
//   i_wr_data    frame to enqueue
//   i_wr_en      enqueue strobe, sampled every cycle
//   o_full       FIFO holds DEPTH entries
//   o_empty      FIFO holds no entries
//   o_level      current FIFO occupancy
//   o_overflow   sticky, set when a write is attempted while full
//   o_tx_data    frame presented to the transmitter
//   o_tx_start   start request; the transmitter acts on its rising edge
//   i_tx_done    transmitter done level, high during the stop bit
//   o_busy       a frame is in flight (sequencer not idle)
//
// All outputs come straight from flops.
// -----------------------------------------------------------------------------
module uart_tx_feeder #(
  parameter int DATA_FRAME = 8,
  parameter int DEPTH      = 16,
  parameter int START_HOLD = 2
) (
  input  logic                       i_clk,
  input  logic                       i_rst,
  input  logic [DATA_FRAME-1:0]      i_wr_data,
  input  logic                       i_wr_en,
  output logic                       o_full,
  output logic                       o_empty,
  output logic [$clog2(DEPTH+1)-1:0] o_level,
  output logic                       o_overflow,
  output logic [DATA_FRAME-1:0]      o_tx_data,
  output logic                       o_tx_start,
  input  logic                       i_tx_done,
  output logic                       o_busy
);

  localparam int AW = $clog2(DEPTH);
  localparam int LW = $clog2(DEPTH + 1);
  localparam int CW = (START_HOLD > 1) ? $clog2(START_HOLD) : 1;

  typedef enum logic [2:0] {
    ST_IDLE    = 3'd0,
    ST_SETUP   = 3'd1,
    ST_START   = 3'd2,
    ST_WAIT_HI = 3'd3,
    ST_WAIT_LO = 3'd4
  } state_t;

  // FIFO storage and bookkeeping
  logic [DATA_FRAME-1:0] r_mem [DEPTH];
  logic [AW-1:0]         r_wr_ptr;
  logic [AW-1:0]         r_rd_ptr;
  logic [LW-1:0]         r_level;
  logic                  r_full;
  logic                  r_empty;
  logic                  r_overflow;

  // Sequencer
  state_t                r_state;
  state_t                w_state_nxt;
  logic [CW-1:0]         r_hold_cnt;
  logic [CW-1:0]         w_hold_cnt_nxt;
  logic                  r_done_seen_lo;
  logic                  w_done_seen_lo_nxt;

  // Registered outputs
  logic [DATA_FRAME-1:0] r_tx_data;
  logic                  r_tx_start;
  logic                  r_busy;

  // Handshake / next-state wires
  logic                  w_wr_accept;
  logic                  w_pop;
  logic [LW-1:0]         w_level_nxt;
  logic                  w_full_nxt;
  logic                  w_empty_nxt;

  // Full is judged on the registered flag, so a write in the same cycle as a
  // pop from a full FIFO is still refused.
  assign w_wr_accept = i_wr_en & ~r_full;

  // Occupancy next-state: a write and a pop together leave the level alone.
  always_comb begin
    w_level_nxt = r_level;
    case ({w_wr_accept, w_pop})
      2'b10:   w_level_nxt = r_level + LW'(1);
      2'b01:   w_level_nxt = r_level - LW'(1);
      default: w_level_nxt = r_level;
    endcase
    w_full_nxt  = (w_level_nxt == LW'(DEPTH));
    w_empty_nxt = (w_level_nxt == LW'(0));
  end

  // FIFO storage write port; contents need no reset because the pointers do.
  always_ff @(posedge i_clk) begin
    if (w_wr_accept) begin
      r_mem[r_wr_ptr] <= i_wr_data;
    end
  end

  // FIFO pointers, occupancy flags and sticky overflow.
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_wr_ptr   <= {AW{1'b0}};
      r_rd_ptr   <= {AW{1'b0}};
      r_level    <= {LW{1'b0}};
      r_full     <= 1'b0;
      r_empty    <= 1'b1;
      r_overflow <= 1'b0;
    end else begin
      // DEPTH is a power of two, so the pointers wrap naturally.
      if (w_wr_accept) begin
        r_wr_ptr <= r_wr_ptr + AW'(1);
      end
      if (w_pop) begin
        r_rd_ptr <= r_rd_ptr + AW'(1);
      end
      r_level <= w_level_nxt;
      r_full  <= w_full_nxt;
      r_empty <= w_empty_nxt;
      if (i_wr_en && r_full) begin
        r_overflow <= 1'b1;
      end
    end
  end

  // Sequencer next-state, pop request and start-hold counter.
  always_comb begin
    w_state_nxt    = r_state;
    w_hold_cnt_nxt = r_hold_cnt;
    w_pop          = 1'b0;
    case (r_state)
      ST_IDLE: begin
        if (!r_empty) begin
          w_pop       = 1'b1;
          w_state_nxt = ST_SETUP;
        end else begin
          w_state_nxt = ST_IDLE;
        end
      end
      ST_SETUP: begin
        // One quiet cycle so the data is settled before the start edge.
        w_state_nxt    = ST_START;
        w_hold_cnt_nxt = {CW{1'b0}};
      end
      ST_START: begin
        if (r_hold_cnt == CW'(START_HOLD - 1)) begin
          w_state_nxt    = ST_WAIT_HI;
          w_hold_cnt_nxt = {CW{1'b0}};
        end else begin
          w_state_nxt    = ST_START;
          w_hold_cnt_nxt = r_hold_cnt + CW'(1);
        end
      end
      ST_WAIT_HI: begin
        // A done level that was already high when this frame was popped
        // belongs to an earlier frame; only a high that follows a low seen
        // during this frame counts.
        if (i_tx_done && r_done_seen_lo) begin
          w_state_nxt = ST_WAIT_LO;
        end else begin
          w_state_nxt = ST_WAIT_HI;
        end
      end
      ST_WAIT_LO: begin
        if (!i_tx_done) begin
          w_state_nxt = ST_IDLE;
        end else begin
          w_state_nxt = ST_WAIT_LO;
        end
      end
      default: begin
        w_state_nxt    = ST_IDLE;
        w_hold_cnt_nxt = {CW{1'b0}};
      end
    endcase
  end

  // Tracks whether i_tx_done has been low since the current frame was popped.
  always_comb begin
    w_done_seen_lo_nxt = r_done_seen_lo;
    if (w_pop) begin
      w_done_seen_lo_nxt = 1'b0;
    end else if ((r_state != ST_IDLE) && !i_tx_done) begin
      w_done_seen_lo_nxt = 1'b1;
    end else begin
      w_done_seen_lo_nxt = r_done_seen_lo;
    end
  end

  // Sequencer state register.
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_state        <= ST_IDLE;
      r_hold_cnt     <= {CW{1'b0}};
      r_done_seen_lo <= 1'b0;
    end else begin
      r_state        <= w_state_nxt;
      r_hold_cnt     <= w_hold_cnt_nxt;
      r_done_seen_lo <= w_done_seen_lo_nxt;
    end
  end

  // Output registers, decoded from the next state so they line up with it.
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_tx_data  <= {DATA_FRAME{1'b0}};
      r_tx_start <= 1'b0;
      r_busy     <= 1'b0;
    end else begin
      // The holding register only changes on a pop, so the frame is stable
      // from SETUP until the sequencer returns to idle.
      if (w_pop) begin
        r_tx_data <= r_mem[r_rd_ptr];
      end
      r_tx_start <= (w_state_nxt == ST_START);
      r_busy     <= (w_state_nxt != ST_IDLE);
    end
  end

  assign o_full     = r_full;
  assign o_empty    = r_empty;
  assign o_level    = r_level;
  assign o_overflow = r_overflow;
  assign o_tx_data  = r_tx_data;
  assign o_tx_start = r_tx_start;
  assign o_busy     = r_busy;

endmodule
